prm_edge_chk_sched: RTL and testbench

//  Sequences a combinational PRM obstacle-logic checker (15-bit query in, 1-bit edge_mask out) over a range of edge codes.

---
 rtl/prm_sched_pkg.sv | 21 ++
 rtl/prm_sched_pack.sv | 72 +++++++
 rtl/prm_edge_chk_sched.sv | 147 ++++++++++++++
 tb/tb_prm_edge_chk_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prm_sched_pkg.sv
// prm_sched_pkg: shared default widths, sequencer state type and command
// record for the PRM edge-checker scheduler (prm_edge_chk_sched).
package prm_sched_pkg;

  localparam int VEC_W_DEF  = 15;
  localparam int LEN_W_DEF  = 16;
  localparam int WORD_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [VEC_W_DEF-1:0] base;
    logic [LEN_W_DEF-1:0] len;
  } sched_cmd_t;

endpackage

// File: rtl/prm_sched_pack.sv
// prm_sched_pack: collects one edge-mask bit per sampled query into a word,
// hands completed words to a registered valid/ready output stage and asks the
// sequencer to stall when a finished word cannot be placed in that stage.
module prm_sched_pack
  import prm_sched_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              sample,
  input  logic              bit_in,
  input  logic              last,
  input  logic              res_ready,
  output logic              stall,
  output logic              res_valid,
  output logic [WORD_W-1:0] res_data,
  output logic              res_last
);

  localparam int POS_W = $clog2(WORD_W);

  logic [WORD_W-1:0] acc_r;
  logic [POS_W-1:0]  pos_r;
  logic              load_need_s;
  logic              load_s;
  logic [WORD_W-1:0] acc_next_s;

  // A word closes on its final bit position or on the command's last query.
  assign load_need_s = (pos_r == POS_W'(WORD_W - 1)) | last;
  // The output stage is free if empty or being drained in this same cycle.
  assign stall       = load_need_s & res_valid & ~res_ready;
  assign load_s      = sample & load_need_s;
  assign acc_next_s  = acc_r | ({{(WORD_W-1){1'b0}}, bit_in} << pos_r);

  // Accumulator and bit position; cleared at each new command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {WORD_W{1'b0}};
      pos_r <= {POS_W{1'b0}};
    end else if (clr) begin
      acc_r <= {WORD_W{1'b0}};
      pos_r <= {POS_W{1'b0}};
    end else if (sample) begin
      if (load_need_s) begin
        acc_r <= {WORD_W{1'b0}};
        pos_r <= {POS_W{1'b0}};
      end else begin
        acc_r <= acc_next_s;
        pos_r <= pos_r + POS_W'(1);
      end
    end
  end

  // Output word register: loads a closed word, drops valid once accepted,
  // and otherwise holds data/last steady under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= {WORD_W{1'b0}};
      res_last  <= 1'b0;
    end else if (load_s) begin
      res_valid <= 1'b1;
      res_data  <= acc_next_s;
      res_last  <= last;
    end else if (res_valid & res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/prm_edge_chk_sched.sv
// prm_edge_chk_sched: walks a range of 15-bit edge codes through one
// combinational PRM obstacle checker, one query per clock, and streams the
// returned masks packed LSB-first into 32-bit words over valid/ready.
// Optional build macro PRM_SCHED_BLKCNT_EN adds blk_cnt, the number of
// queries of the current command whose mask came back 1.
module prm_edge_chk_sched
  import prm_sched_pkg::*;
#(
  parameter int VEC_W  = VEC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [VEC_W-1:0]  cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic [VEC_W-1:0]  chk_vec,
  input  logic              chk_mask,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WORD_W-1:0] res_data,
  output logic              res_last,
  output logic              busy,
  output logic              done
`ifdef PRM_SCHED_BLKCNT_EN
  ,
  output logic [LEN_W-1:0]  blk_cnt
`endif
);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_RUN   = 2'(RUN);
  localparam logic [1:0] S_FLUSH = 2'(FLUSH);
  localparam logic [1:0] S_DONE  = 2'(DONE);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [LEN_W-1:0] remaining_r;
  sched_cmd_t       cmd_s;
  logic             accept_s;
  logic             run_s;
  logic             stall_s;
  logic             sample_s;
  logic             last_s;

  assign cmd_s    = '{base: cmd_base, len: cmd_len};
  assign accept_s = cmd_valid & cmd_ready;
  assign run_s    = (state_r == S_RUN);
  // A query is only consumed on cycles the packer can take its result.
  assign sample_s = run_s & ~stall_s;
  assign last_s   = (remaining_r == LEN_W'(1));

  // Next-state selection for the command sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (cmd_s.len == {LEN_W_DEF{1'b0}}) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_RUN;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (sample_s & last_s) begin
          state_nxt_s = S_FLUSH;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_FLUSH: begin
        if (res_valid & res_ready) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_FLUSH;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Sequencer state plus status flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cmd_ready <= (state_nxt_s == S_IDLE);
      busy      <= (state_nxt_s != S_IDLE);
      done      <= (state_nxt_s == S_DONE);
    end
  end

  // Query generator: current code to the checker and queries still owed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_vec     <= {VEC_W{1'b0}};
      remaining_r <= {LEN_W{1'b0}};
    end else if (accept_s) begin
      chk_vec     <= cmd_s.base;
      remaining_r <= cmd_s.len;
    end else if (sample_s) begin
      chk_vec     <= chk_vec + VEC_W'(1);
      remaining_r <= remaining_r - LEN_W'(1);
    end
  end

`ifdef PRM_SCHED_BLKCNT_EN
  // Blocked-edge tally for the command in flight; held after completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= {LEN_W{1'b0}};
    end else if (accept_s) begin
      blk_cnt <= {LEN_W{1'b0}};
    end else if (sample_s & chk_mask) begin
      blk_cnt <= blk_cnt + LEN_W'(1);
    end
  end
`endif

  prm_sched_pack #(
    .WORD_W (WORD_W)
  ) u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (accept_s),
    .sample    (sample_s),
    .bit_in    (chk_mask),
    .last      (last_s),
    .res_ready (res_ready),
    .stall     (stall_s),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_last  (res_last)
  );

endmodule

// File: tb/tb_prm_edge_chk_sched.sv
// tb_prm_edge_chk_sched: drives commands into prm_edge_chk_sched with a
// behavioural checker model on chk_mask, predicts every result word from the
// range/packing rules, and compares each accepted word on the falling edge.
module tb_prm_edge_chk_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [14:0] cmd_base;
  logic [15:0] cmd_len;
  logic [14:0] chk_vec;
  logic        chk_mask;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_last;
  logic        busy;
  logic        done;
`ifdef PRM_SCHED_BLKCNT_EN
  logic [15:0] blk_cnt;
`endif

  typedef struct {
    logic [31:0] d;
    logic        l;
  } word_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mask_mode = 0;
  logic [15:0] mask_key = 16'h0001;
  int          ready_mode = 0;
  word_t       exp_q[$];
  int          exp_ones = 0;
  logic [31:0] last_acc = 32'h0;
  int          rise_n = 0;
  int          rise_cyc[4];
  int          done_cnt = 0;
  int          n_cmds = 0;

  // monitor-private state
  bit          held_v = 1'b0;
  logic [31:0] held_d = 32'h0;
  logic        held_l = 1'b0;
  logic        prev_done = 1'b0;
  word_t       mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Checker model: mode 0 = vec[0], 1 = keyed parity, 2 = vec < 37.
  function automatic logic mask_fn(input logic [14:0] v, input int mode, input logic [15:0] key);
    case (mode)
      0:       return v[0];
      1:       return (^(v & key[14:0])) ^ key[15];
      2:       return (v < 15'd37);
      default: return 1'b0;
    endcase
  endfunction

  assign chk_mask = mask_fn(chk_vec, mask_mode, mask_key);

  prm_edge_chk_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
    .chk_vec   (chk_vec),
    .chk_mask  (chk_mask),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_last  (res_last),
    .busy      (busy),
    .done      (done)
`ifdef PRM_SCHED_BLKCNT_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ready_mode == 1) res_ready = 1'($urandom_range(0, 1));
    else if (ready_mode == 0) res_ready = 1'b1;
  endtask

  // Expected words: query i is code (base+i) mod 2^15, bit i%32 of word i/32.
  task automatic build_model(input logic [14:0] base, input int len);
    logic [31:0] w;
    logic [14:0] q;
    word_t       e;
    exp_q.delete();
    exp_ones = 0;
    w = 32'h0;
    for (int i = 0; i < len; i++) begin
      q = base + 15'(i);
      if (mask_fn(q, mask_mode, mask_key)) begin
        w[i % 32] = 1'b1;
        exp_ones++;
      end
      if ((i % 32 == 31) || (i == len - 1)) begin
        e.d = w;
        e.l = (i == len - 1);
        exp_q.push_back(e);
        w = 32'h0;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, {31'h0, cmd_ready}, 32'd1);
    chk({tag, "_chk_vec"},   {17'h0, chk_vec},   32'd0);
    chk({tag, "_res_valid"}, {31'h0, res_valid}, 32'd0);
    chk({tag, "_res_data"},  res_data,           32'd0);
    chk({tag, "_res_last"},  {31'h0, res_last},  32'd0);
    chk({tag, "_busy"},      {31'h0, busy},      32'd0);
    chk({tag, "_done"},      {31'h0, done},      32'd0);
`ifdef PRM_SCHED_BLKCNT_EN
    chk({tag, "_blk_cnt"},   {16'h0, blk_cnt},   32'd0);
`endif
  endtask

  // Waits for IDLE, presents one command and returns in the cycle after accept.
  task automatic start_cmd(input logic [14:0] base, input logic [15:0] len, output int a);
    int t = 0;
    while (!cmd_ready && t < 2000) begin
      tick();
      t++;
    end
    chk("idle_wait", {31'h0, cmd_ready}, 32'd1);
    build_model(base, int'(len));
    cmd_base  = base;
    cmd_len   = len;
    cmd_valid = 1'b1;
    a = cyc;
    n_cmds++;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Runs until the done pulse (bounded); records valid rising cycles.
  task automatic finish_cmd(input int a, input int len, input bit junk, output int dlat);
    int   t = 0;
    bit   seen = 1'b0;
    logic pv = 1'b0;
    dlat = -1;
    rise_n = 0;
    while (!seen && t < 4 * len + 400) begin
      if (res_valid && !pv && rise_n < 4) begin
        rise_cyc[rise_n] = cyc - a;
        rise_n++;
      end
      pv = res_valid;
      if (done) begin
        seen = 1'b1;
        dlat = cyc - a;
      end else begin
        if (junk && t == 3) begin
          cmd_valid = 1'b1;
          cmd_base  = 15'($urandom);
          cmd_len   = 16'($urandom);
        end else if (junk && t == 5) begin
          cmd_valid = 1'b0;
        end
        tick();
        t++;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=none expected=done within %0d cycles", 4 * len + 400);
    end
    chk("words_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Compare process: every accepted word against the model, hold stability,
  // done pulse width and cmd_ready/busy consistency.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v    = 1'b0;
      prev_done = 1'b0;
    end else begin
      chk("ready_vs_busy", {31'h0, cmd_ready}, {31'h0, ~busy});
      if (done) begin
        done_cnt++;
        chk("done_width", {31'h0, prev_done}, 32'd0);
      end
      prev_done = done;
      if (res_valid && !res_ready) begin
        if (held_v) begin
          chk("hold_data", res_data, held_d);
          chk("hold_last", {31'h0, res_last}, {31'h0, held_l});
        end
        held_v = 1'b1;
        held_d = res_data;
        held_l = res_last;
      end else begin
        held_v = 1'b0;
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word actual=0x%08h expected=no word", res_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("word_data", res_data, mon_e.d);
          chk("word_last", {31'h0, res_last}, {31'h0, mon_e.l});
          last_acc = res_data;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    int lat;
    int len;
    logic [14:0] base;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_base = 15'h0; cmd_len = 16'h0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Pin the model against hand-computed values.
    mask_mode = 0; build_model(15'h0000, 5);
    chk("pin_single", exp_q[0].d, 32'h0000000A);
    chk("pin_single_n", 32'(exp_q.size()), 32'd1);
    mask_mode = 0; build_model(15'h7FFE, 3);
    chk("pin_wrap", exp_q[0].d, 32'h00000002);
    mask_mode = 2; build_model(15'h0000, 100);
    chk("pin_blk", 32'(exp_ones), 32'd37);
    chk("pin_blk_n", 32'(exp_q.size()), 32'd4);

    // Single word.
    mask_mode = 0; ready_mode = 0;
    start_cmd(15'h0000, 16'd5, a);
    finish_cmd(a, 5, 1'b0, lat);
    chk("t1_first_valid", 32'(rise_cyc[0]), 32'd6);
    chk("t1_done_lat", 32'(lat), 32'd7);
    chk("t1_word", last_acc, 32'h0000000A);

    // Exact word boundary, full throughput.
    mask_mode = 1; mask_key = 16'($urandom) | 16'h0001;
    start_cmd(15'h1234, 16'd64, a);
    finish_cmd(a, 64, 1'b0, lat);
    chk("t2_rises", 32'(rise_n), 32'd2);
    chk("t2_valid1", 32'(rise_cyc[0]), 32'd33);
    chk("t2_valid2", 32'(rise_cyc[1]), 32'd65);
    chk("t2_done_lat", 32'(lat), 32'd66);

    // Backpressure at the first word.
    mask_key = 16'($urandom) | 16'h0001;
    base = 15'h0100;
    ready_mode = 2; res_ready = 1'b0;
    start_cmd(base, 16'd40, a);
    for (int t = 0; t < 100 && !res_valid; t++) tick();
    chk("t3_first_valid", 32'(cyc - a), 32'd33);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k >= 7) chk("t3_vec_frozen", {17'h0, chk_vec}, {17'h0, 15'(base + 15'd39)});
    end
    res_ready = 1'b1; ready_mode = 0;
    finish_cmd(a, 40, 1'b0, lat);

    // Code wrap.
    mask_mode = 0;
    start_cmd(15'h7FFE, 16'd3, a);
    chk("t4_vec0", {17'h0, chk_vec}, 32'h00007FFE);
    tick();
    chk("t4_vec1", {17'h0, chk_vec}, 32'h00007FFF);
    tick();
    chk("t4_vec2", {17'h0, chk_vec}, 32'h00000000);
    finish_cmd(a, 3, 1'b0, lat);
    chk("t4_word", last_acc, 32'h00000002);

    // Empty command.
    start_cmd(15'h0055, 16'd0, a);
    finish_cmd(a, 0, 1'b0, lat);
    chk("t5_done_lat", 32'(lat), 32'd1);
    chk("t5_no_valid", 32'(rise_n), 32'd0);
    tick();
    chk("t5_idle", {31'h0, cmd_ready}, 32'd1);

    // Reset mid-RUN, then a clean command.
    mask_mode = 1; mask_key = 16'($urandom) | 16'h0001;
    start_cmd(15'($urandom), 16'd200, a);
    repeat (50) tick();
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6");
    exp_q.delete();
    n_cmds--;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    start_cmd(15'h2000, 16'd20, a);
    finish_cmd(a, 20, 1'b0, lat);
    chk("t6_clean_lat", 32'(lat), 32'd22);

    // Blocked-edge count command.
    mask_mode = 2;
    start_cmd(15'h0000, 16'd100, a);
    finish_cmd(a, 100, 1'b0, lat);
`ifdef PRM_SCHED_BLKCNT_EN
    chk("t7_blk_cnt", {16'h0, blk_cnt}, 32'd37);
    chk("t7_blk_model", {16'h0, blk_cnt}, 32'(exp_ones));
`endif

    // Randomized commands with random backpressure and ignored requests.
    mask_mode = 1;
    for (int n = 0; n < 25; n++) begin
      mask_key   = 16'($urandom) | 16'h0001;
      ready_mode = int'($urandom_range(0, 1));
      len        = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 130));
      start_cmd(15'($urandom), 16'(len), a);
      finish_cmd(a, len, (len >= 12), lat);
      if (ready_mode == 0) chk("rnd_done_lat", 32'(lat), 32'(len == 0 ? 1 : len + 2));
    end
    ready_mode = 0;
    tick();
    tick();
    chk("done_count", 32'(done_cnt), 32'(n_cmds));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
